// File: rtl/jtvigil_scr2_fetch_pkg.sv
// jtvigil_scr2_pkg: shared types and constants for the scroll-2 line fetcher.
//   state_t   - fetch FSM encoding
//   shadow_t  - per-line snapshot of the CPU registers and the line number
//   WORDS_PER_LINE / PIX_PER_WORD / LINE_PIX - line geometry
package jtvigil_scr2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAW  = 3'd3,
    ST_BLANK = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // 33 words cover 256 pixels plus up to 7 pixels of fine-scroll slack.
  localparam int WORDS_PER_LINE = 33;
  localparam int PIX_PER_WORD   = 8;
  localparam int LINE_PIX       = 256;

  typedef struct packed {
    logic [10:0] scrx;
    logic [3:0]  bank;
    logic        en;
    logic [7:0]  row;
  } shadow_t;

endpackage

// File: rtl/jtvigil_scr2_fetch_if.sv
// jtvigil_scr2_fetch_if: ROM request channel and line-buffer write port.
//   rom_addr/rom_cs  - word request (fetcher drives)
//   rom_ok/rom_data  - SDRAM answer (memory side drives)
//   buf_we/buf_addr/buf_data - line-buffer write (fetcher drives)
// master = fetcher side, slave = memory / line-buffer side.
interface jtvigil_scr2_fetch_if #(
  parameter int ROM_AW = 16
) ();
  logic [ROM_AW-1:0] rom_addr;
  logic              rom_cs;
  logic              rom_ok;
  logic [31:0]       rom_data;
  logic              buf_we;
  logic [7:0]        buf_addr;
  logic [7:0]        buf_data;

  modport master (
    output rom_addr, rom_cs, buf_we, buf_addr, buf_data,
    input  rom_ok, rom_data
  );

  modport slave (
    input  rom_addr, rom_cs, buf_we, buf_addr, buf_data,
    output rom_ok, rom_data
  );
endinterface

// File: rtl/jtvigil_scr2_fetch_regs.sv
// jtvigil_scr2_regs: CPU-visible scroll/colour registers, hs edge detect,
// per-line shadow copies and the optional overrun counter.
// Optional feature macro: JTVIGIL_SCR2_OVERRUN_EN (overrun counter).
//   clk, rst_n        - clock, asynchronous active-low reset
//   hs_i, vrender_i   - line sync and line number
//   cpu_dout_i, *_we_i - CPU register writes
//   abort_i           - the fetcher abandoned a fill this cycle
//   start_o           - one-cycle pulse, a new line begins (shadows valid)
//   shadow_o          - registers frozen for the current line
//   overruns_o        - saturating count of aborted fills
module jtvigil_scr2_regs
  import jtvigil_scr2_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hs_i,
  input  logic [7:0] vrender_i,
  input  logic [7:0] cpu_dout_i,
  input  logic       scrx_lo_we_i,
  input  logic       scrx_hi_we_i,
  input  logic       scr2col_we_i,
  input  logic       abort_i,
  output logic       start_o,
  output shadow_t    shadow_o,
  output logic [7:0] overruns_o
);

  logic [10:0] scrx_q;
  logic [3:0]  bank_q;
  logic        en_q;
  logic        hs_q;
  logic        start_q;
  shadow_t     shadow_q;
  logic        hs_rise;

  assign hs_rise = hs_i & ~hs_q;

  // Shadows load on the same edge that raises start_q, so they are already
  // valid in the cycle the FSM reacts to start_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scrx_q   <= '0;
      bank_q   <= '0;
      en_q     <= 1'b0;
      hs_q     <= 1'b0;
      start_q  <= 1'b0;
      shadow_q <= '0;
    end else begin
      hs_q    <= hs_i;
      start_q <= hs_rise;
      if (scrx_lo_we_i) scrx_q[7:0]  <= cpu_dout_i;
      if (scrx_hi_we_i) scrx_q[10:8] <= cpu_dout_i[2:0];
      if (scr2col_we_i) begin
        bank_q <= cpu_dout_i[3:0];
        en_q   <= cpu_dout_i[4];
      end
      if (hs_rise) begin
        shadow_q <= '{scrx: scrx_q, bank: bank_q, en: en_q, row: vrender_i};
      end
    end
  end

  assign start_o  = start_q;
  assign shadow_o = shadow_q;

`ifdef JTVIGIL_SCR2_OVERRUN_EN
  logic [7:0] ovr_q;
  logic [7:0] ovr_d;

  always_comb begin
    ovr_d = ovr_q;
    if (scr2col_we_i) begin
      ovr_d = 8'd0;
    end else if (abort_i && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovr_q <= 8'd0;
    else        ovr_q <= ovr_d;
  end

  assign overruns_o = ovr_q;
`else
  logic unused_abort;
  assign unused_abort = abort_i;
  assign overruns_o   = 8'd0;
`endif

endmodule

// File: rtl/jtvigil_scr2_fetch.sv
// jtvigil_scr2_fetch: per-line fetch scheduler for the scroll-2 bitmap layer.
// On each hs rising edge it freezes the scroll/colour registers, fetches 33
// ROM words and writes a full 256-pixel line into the line buffer (or 256
// zeros when the layer is disabled).
// Optional feature macro: JTVIGIL_SCR2_OVERRUN_EN (overrun counter).
//   clk, rst_n     - clock, asynchronous active-low reset
//   hs, vrender    - line start and line number
//   cpu_dout, scrx_lo_we, scrx_hi_we, scr2col_we - CPU register writes
//   bus            - ROM request channel and line-buffer write port
//   busy           - a line fill is in progress
//   overruns       - aborted-fill counter (0 when the feature is off)
module jtvigil_scr2_fetch
  import jtvigil_scr2_pkg::*;
#(
  parameter int          ROM_AW  = 16,
  parameter logic [10:0] HOFFSET = 11'd0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hs,
  input  logic [7:0]            vrender,
  input  logic [7:0]            cpu_dout,
  input  logic                  scrx_lo_we,
  input  logic                  scrx_hi_we,
  input  logic                  scr2col_we,
  jtvigil_scr2_fetch_if.master  bus,
  output logic                  busy,
  output logic [7:0]            overruns
);

  logic    start;
  logic    abort;
  shadow_t sh;

  state_t            state_q;
  logic [5:0]        n_q;
  logic [2:0]        k_q;
  logic [7:0]        bcnt_q;
  logic [31:0]       word_q;
  logic [ROM_AW-1:0] rom_addr_q;
  logic              rom_cs_q;
  logic              buf_we_q;
  logic [7:0]        buf_addr_q;
  logic [7:0]        buf_data_q;
  logic              busy_q;

  // A new line arriving while a fill is still running is an overrun.
  assign abort = start && (state_q inside {ST_REQ, ST_WAIT, ST_DRAW, ST_BLANK});

  jtvigil_scr2_regs u_regs (
    .clk          (clk),
    .rst_n        (rst_n),
    .hs_i         (hs),
    .vrender_i    (vrender),
    .cpu_dout_i   (cpu_dout),
    .scrx_lo_we_i (scrx_lo_we),
    .scrx_hi_we_i (scrx_hi_we),
    .scr2col_we_i (scr2col_we),
    .abort_i      (abort),
    .start_o      (start),
    .shadow_o     (sh),
    .overruns_o   (overruns)
  );

  logic [10:0] sx;
  logic [7:0]  c0;
  logic [2:0]  fine;
  logic [7:0]  col;
  logic [10:0] pix_pos;
  logic        pix_in_line;

  assign sx   = sh.scrx + HOFFSET;
  assign c0   = sx[10:3];
  assign fine = sx[2:0];
  assign col  = c0 + {2'b00, n_q};

  // Screen position of pixel k of word n: 8n + k - f. Negative results
  // (leading fine-scroll pixels) and results past 255 set the upper bits.
  assign pix_pos     = {2'b00, n_q, k_q} - {8'd0, fine};
  assign pix_in_line = (pix_pos[10:8] == 3'b000);

  logic [3:0] word_pix [PIX_PER_WORD];

  for (genvar gi = 0; gi < PIX_PER_WORD; gi++) begin : g_unpack
    assign word_pix[gi] = word_q[4*gi +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      k_q        <= '0;
      bcnt_q     <= '0;
      word_q     <= '0;
      rom_addr_q <= '0;
      rom_cs_q   <= 1'b0;
      buf_we_q   <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      buf_we_q <= 1'b0;
      if (start) begin
        // Normal start or overrun restart: drop any request, begin at n=0.
        state_q  <= sh.en ? ST_REQ : ST_BLANK;
        busy_q   <= 1'b1;
        rom_cs_q <= 1'b0;
        n_q      <= '0;
        k_q      <= '0;
        bcnt_q   <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE: ;
          ST_REQ: begin
            rom_addr_q <= ROM_AW'({sh.row, col});
            rom_cs_q   <= 1'b1;
            state_q    <= ST_WAIT;
          end
          ST_WAIT: begin
            if (bus.rom_ok) begin
              word_q   <= bus.rom_data;
              rom_cs_q <= 1'b0;
              k_q      <= '0;
              state_q  <= ST_DRAW;
            end
          end
          ST_DRAW: begin
            buf_we_q   <= pix_in_line;
            buf_addr_q <= pix_pos[7:0];
            buf_data_q <= {sh.bank, word_pix[k_q]};
            k_q        <= k_q + 3'd1;
            if (k_q == 3'(PIX_PER_WORD - 1)) begin
              n_q     <= n_q + 6'd1;
              state_q <= (n_q == 6'(WORDS_PER_LINE - 1)) ? ST_DONE : ST_REQ;
            end
          end
          ST_BLANK: begin
            buf_we_q   <= 1'b1;
            buf_addr_q <= bcnt_q;
            buf_data_q <= 8'd0;
            bcnt_q     <= bcnt_q + 8'd1;
            if (bcnt_q == 8'(LINE_PIX - 1)) state_q <= ST_DONE;
          end
          ST_DONE: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.rom_cs   = rom_cs_q;
  assign bus.buf_we   = buf_we_q;
  assign bus.buf_addr = buf_addr_q;
  assign bus.buf_data = buf_data_q;
  assign busy         = busy_q;

endmodule
